// File: rtl/cpu_sram_arbiter_pkg.sv
// Shared definitions for the CPU SRAM-port arbiter.
// - arb_state_e: arbiter FSM states (idle / address phase / data phase)
// - Sz*: access size codes carried on inst_size, data_size and bus_size
// - Own*: owner codes recording which requester holds the bus transaction
package cpu_sram_arbiter_pkg;

    typedef enum logic [1:0] {
        ArbIdle = 2'd0,
        ArbAddr = 2'd1,
        ArbData = 2'd2
    } arb_state_e;

    localparam logic [1:0] SzByte = 2'd0;
    localparam logic [1:0] SzHalf = 2'd1;
    localparam logic [1:0] SzWord = 2'd2;

    localparam logic OwnInst = 1'b0;
    localparam logic OwnData = 1'b1;

endpackage

// File: rtl/cpu_sram_arb_pick.sv
// Priority decision plus the anti-starvation counter.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   inst_req, data_req  pending requests from fetch and load/store
//   grant               high in the cycle the top module accepts a winner
//   inst_win            high when fetch wins the current arbitration
// Data normally wins. The counter tracks consecutive data grants taken while
// fetch was waiting; at STARVE_MAX fetch is forced through.
// CNT_WD must be wide enough to hold STARVE_MAX (2**CNT_WD > STARVE_MAX).
module cpu_sram_arb_pick #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned CNT_WD     = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic inst_req,
    input  logic data_req,
    input  logic grant,
    output logic inst_win
);

    localparam logic [CNT_WD-1:0] CntMax = CNT_WD'(STARVE_MAX);

    logic [CNT_WD-1:0] cnt_q, cnt_d;

    assign inst_win = inst_req && (!data_req || (cnt_q == CntMax));

    always_comb begin
        cnt_d = cnt_q;
        if (grant) begin
            if (!inst_win && inst_req) begin
                // Data jumped a waiting fetch; count it, saturating.
                cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cpu_sram_arbiter.sv
// Shares one sram-like memory port between instruction fetch and data access.
// One transaction is outstanding at a time: IDLE arbitrates and latches the
// winner's fields, ADDR presents them until bus_addr_ok, DATA waits for
// bus_data_ok. Handshakes back to the owner are combinational from the bus.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   inst_req/size/addr               fetch request (read-only)
//   inst_addr_ok/data_ok/rdata       fetch handshake and read data
//   data_req/wr/size/addr/wdata      load/store request
//   data_addr_ok/data_ok/rdata       load/store handshake and read data
//   bus_req/wr/size/addr/wdata       request to the memory bridge
//   bus_addr_ok/data_ok/rdata        bridge handshake and read data
module cpu_sram_arbiter
    import cpu_sram_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned CNT_WD     = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    arb_state_e state_q, state_d;
    logic       owner_q;
    logic       grant;
    logic       inst_win;

    assign grant = (state_q == ArbIdle) && (inst_req || data_req);

    cpu_sram_arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_WD     (CNT_WD)
    ) u_pick (
        .clk      (clk),
        .reset    (reset),
        .inst_req (inst_req),
        .data_req (data_req),
        .grant    (grant),
        .inst_win (inst_win)
    );

    // Both read-data outputs see the bus; only the owner's data_ok qualifies it.
    assign inst_rdata = bus_rdata;
    assign data_rdata = bus_rdata;

    always_comb begin
        state_d      = state_q;
        bus_req      = 1'b0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        unique case (state_q)
            ArbIdle: begin
                if (grant) begin
                    state_d = ArbAddr;
                end
            end
            ArbAddr: begin
                bus_req = 1'b1;
                if (bus_addr_ok) begin
                    state_d      = ArbData;
                    inst_addr_ok = (owner_q == OwnInst);
                    data_addr_ok = (owner_q == OwnData);
                end
            end
            ArbData: begin
                if (bus_data_ok) begin
                    state_d      = ArbIdle;
                    inst_data_ok = (owner_q == OwnInst);
                    data_data_ok = (owner_q == OwnData);
                end
            end
            default: begin
                state_d = ArbIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ArbIdle;
            owner_q   <= OwnInst;
            bus_wr    <= 1'b0;
            bus_size  <= SzByte;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            state_q <= state_d;
            // Fields are latched once at grant and held through ADDR so the
            // bridge sees a stable request regardless of requester activity.
            if (grant) begin
                if (inst_win) begin
                    owner_q   <= OwnInst;
                    bus_wr    <= 1'b0;
                    bus_size  <= inst_size;
                    bus_addr  <= inst_addr;
                    bus_wdata <= '0;
                end else begin
                    owner_q   <= OwnData;
                    bus_wr    <= data_wr;
                    bus_size  <= data_size;
                    bus_addr  <= data_addr;
                    bus_wdata <= data_wdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
module tb_cpu_sram_arbiter;

    localparam int StarveMax = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;

    cpu_sram_arbiter #(
        .STARVE_MAX (StarveMax),
        .CNT_WD     (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .bus_req      (bus_req),
        .bus_wr       (bus_wr),
        .bus_size     (bus_size),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_addr_ok  (bus_addr_ok),
        .bus_data_ok  (bus_data_ok),
        .bus_rdata    (bus_rdata)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk32(name, {31'b0, act}, {31'b0, exp});
    endtask

    // ---------------- bridge and requester stimulus ----------------
    int   aw_cfg, dw_cfg;      // bridge wait cycles; negative = random 0..3
    int   b_phase, b_cnt;      // 0 none, 1 address pending, 2 data pending
    bit   spur_en, auto_req, fix_rdata_en;
    logic [31:0] fix_rdata;
    logic seen_i, seen_d;

    function automatic int pick_wait(int cfg);
        return (cfg < 0) ? int'($urandom_range(0, 3)) : cfg;
    endfunction

    task automatic bridge_drive();
        int ph0;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = fix_rdata_en ? fix_rdata : $urandom;
        if (reset) b_phase = 0;  // bridge shares the arbiter's reset
        ph0 = b_phase;
        if (b_phase == 0 && bus_req) begin
            b_phase = 1;
            b_cnt   = pick_wait(aw_cfg);
        end
        if (b_phase == 1) begin
            if (b_cnt == 0) begin
                bus_addr_ok = 1'b1;
                b_phase     = 2;
                b_cnt       = pick_wait(dw_cfg);
            end else begin
                b_cnt--;
            end
        end else if (b_phase == 2) begin
            if (b_cnt == 0) begin
                bus_data_ok = 1'b1;
                b_phase     = 0;
            end else begin
                b_cnt--;
            end
        end
        if (spur_en) begin
            if (!bus_req && $urandom_range(0, 3) == 0) bus_addr_ok = 1'b1;
            if (ph0 != 2 && !bus_addr_ok && $urandom_range(0, 3) == 0) bus_data_ok = 1'b1;
        end
    endtask

    task automatic req_drive();
        if (seen_i || !inst_req) begin
            inst_req  = ($urandom_range(0, 3) != 0);
            inst_size = 2'($urandom_range(0, 2));
            inst_addr = $urandom;
        end
        if (seen_d || !data_req) begin
            data_req   = ($urandom_range(0, 2) != 0);
            data_wr    = 1'($urandom);
            data_size  = 2'($urandom_range(0, 2));
            data_addr  = $urandom;
            data_wdata = $urandom;
        end
        reset = ($urandom_range(0, 99) == 0);
    endtask

    // Ends 1 time unit after the next rising edge with bridge inputs driven.
    task automatic tick();
        @(negedge clk);
        seen_i = inst_addr_ok;
        seen_d = data_addr_ok;
        @(posedge clk);
        #1;
        bridge_drive();
        if (auto_req) req_drive();
    endtask

    // ---------------- transaction-level reference model ----------------
    bit          m_valid = 0;
    bit          m_busy, m_addr_done, m_own_data;
    int          m_starve;
    logic        m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata;
    logic        e_req, e_iaok, e_daok, e_idok, e_ddok;

    always @(negedge clk) begin
        if (m_valid) begin
            e_req  = m_busy && !m_addr_done;
            e_iaok = e_req && bus_addr_ok && !m_own_data;
            e_daok = e_req && bus_addr_ok && m_own_data;
            e_idok = m_busy && m_addr_done && bus_data_ok && !m_own_data;
            e_ddok = m_busy && m_addr_done && bus_data_ok && m_own_data;
            chk1("bus_req", bus_req, e_req);
            chk1("bus_wr", bus_wr, m_wr);
            chk32("bus_size", {30'b0, bus_size}, {30'b0, m_size});
            chk32("bus_addr", bus_addr, m_addr);
            chk32("bus_wdata", bus_wdata, m_wdata);
            chk1("inst_addr_ok", inst_addr_ok, e_iaok);
            chk1("data_addr_ok", data_addr_ok, e_daok);
            chk1("inst_data_ok", inst_data_ok, e_idok);
            chk1("data_data_ok", data_data_ok, e_ddok);
            if (e_idok) chk32("inst_rdata", inst_rdata, bus_rdata);
            if (e_ddok && !m_wr) chk32("data_rdata", data_rdata, bus_rdata);
        end
        if (reset) begin
            m_valid     = 1;
            m_busy      = 0;
            m_addr_done = 0;
            m_own_data  = 0;
            m_starve    = 0;
            m_wr        = 1'b0;
            m_size      = 2'd0;
            m_addr      = '0;
            m_wdata     = '0;
        end else if (m_valid) begin
            if (!m_busy) begin
                if (inst_req || data_req) begin
                    m_own_data = !(inst_req && (!data_req || m_starve == StarveMax));
                    if (m_own_data) begin
                        m_wr     = data_wr;
                        m_size   = data_size;
                        m_addr   = data_addr;
                        m_wdata  = data_wdata;
                        m_starve = inst_req ? ((m_starve < StarveMax) ? m_starve + 1 : StarveMax)
                                            : 0;
                    end else begin
                        m_wr     = 1'b0;
                        m_size   = inst_size;
                        m_addr   = inst_addr;
                        m_wdata  = '0;
                        m_starve = 0;
                    end
                    m_busy      = 1;
                    m_addr_done = 0;
                end
            end else if (!m_addr_done) begin
                if (bus_addr_ok) m_addr_done = 1;
            end else if (bus_data_ok) begin
                m_busy = 0;
            end
        end
    end

    // ---------------- directed scenarios then random traffic ----------------
    initial begin
        reset = 1'b1;
        inst_req = 0; inst_size = 0; inst_addr = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
        aw_cfg = 0; dw_cfg = 0; b_phase = 0; b_cnt = 0;
        spur_en = 0; auto_req = 0; fix_rdata_en = 1; fix_rdata = 32'h3C1D_0001;
        seen_i = 0; seen_d = 0;

        tick(); tick();
        reset = 1'b0;
        #3;
        chk1("rst bus_req", bus_req, 1'b0);
        chk1("rst bus_wr", bus_wr, 1'b0);
        chk32("rst bus_addr", bus_addr, 32'h0);
        chk32("rst bus_wdata", bus_wdata, 32'h0);
        chk32("rst bus_size", {30'b0, bus_size}, 32'h0);
        chk1("rst ok", inst_addr_ok | data_addr_ok | inst_data_ok | data_data_ok, 1'b0);

        // Single zero-wait fetch.
        tick(); inst_req = 1; inst_size = 2'd2; inst_addr = 32'hBFC0_0000; #3;
        chk1("fetch idle bus_req", bus_req, 1'b0);
        tick(); #3;
        chk1("fetch bus_req", bus_req, 1'b1);
        chk32("fetch bus_addr", bus_addr, 32'hBFC0_0000);
        chk1("fetch bus_wr", bus_wr, 1'b0);
        chk1("fetch addr_ok", inst_addr_ok, 1'b1);
        tick(); inst_req = 0; #3;
        chk1("fetch data_ok", inst_data_ok, 1'b1);
        chk32("fetch rdata", inst_rdata, 32'h3C1D_0001);

        // Simultaneous: data store first, then fetch.
        tick();
        inst_req = 1; inst_addr = 32'h100;
        data_req = 1; data_wr = 1; data_size = 2'd2; data_addr = 32'h8000_1000;
        data_wdata = 32'hDEAD_BEEF;
        #3;
        tick(); #3;
        chk1("sim data addr_ok", data_addr_ok, 1'b1);
        chk1("sim inst no addr_ok", inst_addr_ok, 1'b0);
        chk1("sim bus_wr", bus_wr, 1'b1);
        chk32("sim bus_wdata", bus_wdata, 32'hDEAD_BEEF);
        chk32("sim bus_addr", bus_addr, 32'h8000_1000);
        tick(); data_req = 0; #3;
        chk1("sim store done", data_data_ok, 1'b1);
        tick(); #3;
        tick(); #3;
        chk32("sim inst bus_addr", bus_addr, 32'h100);
        chk1("sim inst addr_ok", inst_addr_ok, 1'b1);
        chk32("sim inst wdata", bus_wdata, 32'h0);
        tick(); inst_req = 0; #3;
        chk1("sim inst data_ok", inst_data_ok, 1'b1);

        // Starvation: both held, expect DDDDI repeating.
        for (int g = 0; g < 15; g++) begin
            tick();
            if (g == 0) begin
                inst_req = 1; inst_addr = 32'h200;
                data_req = 1; data_wr = 0; data_addr = 32'h300;
            end
            tick(); #3;
            chk1("starve inst grant", inst_addr_ok, (g % 5) == 4);
            chk1("starve data grant", data_addr_ok, (g % 5) != 4);
            tick();
            if (g == 14) begin inst_req = 0; data_req = 0; end
        end

        // Slow bridge: address 3 waits, data 5 waits.
        aw_cfg = 3; dw_cfg = 5;
        tick(); data_req = 1; data_wr = 0; data_size = 2'd1; data_addr = 32'h2000; #3;
        for (int k = 0; k < 3; k++) begin
            tick(); #3;
            chk1("slow bus_req", bus_req, 1'b1);
            chk32("slow bus_addr", bus_addr, 32'h2000);
            chk1("slow early addr_ok", data_addr_ok, 1'b0);
        end
        tick(); #3;
        chk1("slow addr_ok", data_addr_ok, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 0) begin
                data_wr = 1; data_size = 2'd2; data_addr = 32'h3000; data_wdata = 32'h1234_5678;
            end
            #3;
            chk1("slow early data_ok", data_data_ok, 1'b0);
            chk1("slow new req not acked", data_addr_ok, 1'b0);
        end
        tick(); aw_cfg = 0; dw_cfg = 0; #3;
        chk1("slow data_ok", data_data_ok, 1'b1);
        tick(); #3;
        tick(); #3;
        chk1("slow 2nd addr_ok", data_addr_ok, 1'b1);
        chk32("slow 2nd bus_addr", bus_addr, 32'h3000);
        tick(); data_req = 0; #3;
        chk1("slow 2nd data_ok", data_data_ok, 1'b1);

        // Reset while a load is in its data phase.
        tick(); data_req = 1; data_wr = 0; data_addr = 32'h4000; dw_cfg = 5; #3;
        tick(); #3;
        chk1("rstmid addr_ok", data_addr_ok, 1'b1);
        tick(); data_req = 0; reset = 1; #3;
        tick(); reset = 0; dw_cfg = 0; #3;
        chk1("rstmid bus_req", bus_req, 1'b0);
        chk32("rstmid bus_addr", bus_addr, 32'h0);
        tick(); bus_data_ok = 1; #3;
        chk1("rstmid stale data_ok", data_data_ok, 1'b0);

        // Spurious bridge handshakes.
        tick(); bus_data_ok = 1; #3;
        chk1("spur idle data_ok", inst_data_ok | data_data_ok, 1'b0);
        tick(); bus_addr_ok = 1; #3;
        chk1("spur idle addr_ok", inst_addr_ok | data_addr_ok, 1'b0);
        chk1("spur idle bus_req", bus_req, 1'b0);
        tick(); inst_req = 1; inst_addr = 32'h500; dw_cfg = 2; #3;
        tick(); #3;
        chk1("spur fetch addr_ok", inst_addr_ok, 1'b1);
        for (int k = 0; k < 2; k++) begin
            tick(); inst_req = 0; bus_addr_ok = 1; #3;
            chk1("spur data-phase addr_ok", inst_addr_ok, 1'b0);
            chk1("spur data-phase bus_req", bus_req, 1'b0);
        end
        tick(); #3;
        chk1("spur fetch data_ok", inst_data_ok, 1'b1);

        // Random traffic against the model.
        aw_cfg = -1; dw_cfg = -1; fix_rdata_en = 0; spur_en = 1; auto_req = 1;
        repeat (4000) tick();
        auto_req = 0; spur_en = 0; inst_req = 0; data_req = 0; reset = 0;
        tick(); tick();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
